// File: rtl/dac_serializer.sv
// Purpose : serialises NUM_CH parallel DAC words onto shared sync/sclk with one data line per channel.
// Latency : first bit on dout the cycle after accept; done pulses DATA_W*2*CLK_DIV+1 cycles after accept.
// Backpr. : load_ready is high only in IDLE; load_valid/load_data are ignored while a frame or gap runs.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   reset      synchronous active-high reset; aborts any frame without a done pulse
//   load_data  channel k word at bits [k*DATA_W +: DATA_W]
//   load_valid load_data valid this cycle
//   load_ready frame accepted on an edge where load_valid & load_ready
//   sclk       serial clock, idles high; DAC samples on the falling edge (mid-bit)
//   dout       serial data, bit k drives channel k
//   sync       frame sync, low for exactly DATA_W*2*CLK_DIV cycles per frame
//   busy       high while shifting or in the post-frame gap
//   done       one-cycle pulse in the first gap cycle of a completed frame

module dac_serializer #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int CLK_DIV   = 2,
  parameter int GAP_CYC   = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     sclk,
  output logic [NUM_CH-1:0]        dout,
  output logic                     sync,
  output logic                     busy,
  output logic                     done
);

  // One bit period spans DIV_N clk cycles; counters are sized to hold
  // their terminal count so none of them wraps early.
  localparam int DIV_N = 2 * CLK_DIV;
  localparam int DW    = $clog2(DIV_N);
  localparam int BW    = $clog2(DATA_W);
  localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_N - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [DW-1:0]                   div_q,   div_d;
  logic [BW-1:0]                   bit_q,   bit_d;
  logic [GW-1:0]                   gap_q,   gap_d;
  logic [NUM_CH-1:0][DATA_W-1:0]   sreg_q,  sreg_d;

  logic                            ready_q, ready_d;
  logic                            sclk_q,  sclk_d;
  logic [NUM_CH-1:0]               dout_q,  dout_d;
  logic                            sync_q,  sync_d;
  logic                            busy_q,  busy_d;
  logic                            done_q,  done_d;

  // Bit presented first on the line for a given register content.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return w[DATA_W-1];
    else                return w[0];
  endfunction

  // Advance by one bit, zero-filling the vacated end so the register
  // is empty once the whole word has gone out.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) return {w[DATA_W-2:0], 1'b0};
    else                return {1'b0, w[DATA_W-1:1]};
  endfunction

  // Next-state and output logic. Outputs are computed one cycle ahead so
  // the pins come straight from flops.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sreg_d  = sreg_q;
    ready_d = ready_q;
    sclk_d  = sclk_q;
    dout_d  = dout_q;
    sync_d  = sync_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid && ready_q) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          for (int k = 0; k < NUM_CH; k++) begin
            sreg_d[k] = load_data[k*DATA_W +: DATA_W];
            dout_d[k] = first_bit(sreg_d[k]);
          end
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          // End of bit period == sclk rising edge: move every lane on.
          div_d = '0;
          for (int k = 0; k < NUM_CH; k++) begin
            sreg_d[k] = shift_word(sreg_q[k]);
          end
          sclk_d = 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
            gap_d   = '0;
            sync_d  = 1'b1;
            dout_d  = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
              dout_d[k] = first_bit(sreg_d[k]);
            end
          end
        end else begin
          // sclk high for the first half of the bit, low for the second.
          div_d  = div_q + 1'b1;
          sclk_d = (div_d < DIV_HALF);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
        gap_d   = '0;
        sreg_d  = '0;
        ready_d = 1'b1;
        sclk_d  = 1'b1;
        dout_d  = '0;
        sync_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sreg_q  <= '0;
      ready_q <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= '0;
      sync_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sreg_q  <= sreg_d;
      ready_q <= ready_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = ready_q;
  assign sclk       = sclk_q;
  assign dout       = dout_q;
  assign sync       = sync_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: default instance (2 channels, MSB first, CLK_DIV=2)
// plus an LSB-first, CLK_DIV=1 single-channel instance. A monitor rebuilds each
// frame from dout at sclk falling edges; scenario tasks compare against queued words.

module tb_dac_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready, sclk, sync, busy, done;
  logic [1:0]  dout;

  logic [15:0] b_load_data;
  logic        b_load_valid;
  logic        b_load_ready, b_sclk, b_sync, b_busy, b_done;
  logic [0:0]  b_dout;

  dac_serializer u_dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .sclk(sclk), .dout(dout), .sync(sync),
    .busy(busy), .done(done)
  );

  dac_serializer #(.DATA_W(16), .NUM_CH(1), .CLK_DIV(1), .GAP_CYC(1), .MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .reset(reset), .load_data(b_load_data), .load_valid(b_load_valid),
    .load_ready(b_load_ready), .sclk(b_sclk), .dout(b_dout), .sync(b_sync),
    .busy(b_busy), .done(b_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard queues: exp* filled when a frame is driven, obs* by the monitor.
  logic [15:0] exp0[$], exp1[$], obs0[$], obs1[$];
  int          low_q[$], hi_q[$];
  logic [15:0] b_exp[$], b_obs[$];
  logic        b_first_q[$];
  int          b_low_q[$];

  // Monitor for the default instance.
  logic [15:0] cur0 = '0, cur1 = '0;
  int          low_run = 0, hi_run = 0, done_cnt = 0;
  logic        prev_sclk = 1'b1, prev_sync = 1'b1;

  always @(negedge clk) begin
    if (sync === 1'b0) begin
      low_run++;
      if (prev_sclk === 1'b1 && sclk === 1'b0) begin
        cur0 = {cur0[14:0], dout[0]};
        cur1 = {cur1[14:0], dout[1]};
      end
    end
    if (sync === 1'b1) hi_run++;
    if (sync === 1'b1 && prev_sync === 1'b0) begin
      obs0.push_back(cur0);
      obs1.push_back(cur1);
      low_q.push_back(low_run);
      low_run = 0; cur0 = '0; cur1 = '0;
    end
    if (sync === 1'b0 && prev_sync === 1'b1) begin
      hi_q.push_back(hi_run);
      hi_run = 0;
    end
    if (done === 1'b1) done_cnt++;
    prev_sclk = sclk;
    prev_sync = sync;
  end

  // Monitor for the LSB-first instance.
  logic [15:0] b_cur = '0;
  int          b_low_run = 0, b_nbits = 0;
  logic        b_first = 1'b0;
  logic        b_prev_sclk = 1'b1, b_prev_sync = 1'b1;

  always @(negedge clk) begin
    if (b_sync === 1'b0) begin
      b_low_run++;
      if (b_prev_sclk === 1'b1 && b_sclk === 1'b0) begin
        if (b_nbits == 0) b_first = b_dout[0];
        b_cur = {b_cur[14:0], b_dout[0]};
        b_nbits++;
      end
    end
    if (b_sync === 1'b1 && b_prev_sync === 1'b0) begin
      b_obs.push_back(b_cur);
      b_first_q.push_back(b_first);
      b_low_q.push_back(b_low_run);
      b_low_run = 0; b_cur = '0; b_nbits = 0;
    end
    b_prev_sclk = b_sclk;
    b_prev_sync = b_sync;
  end

  // Sample/drive point: just after the falling edge, after the monitors ran.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic flush_obs();
    obs0.delete(); obs1.delete(); low_q.delete(); hi_q.delete();
    exp0.delete(); exp1.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    vectors++;
    if ({sync, sclk, dout, load_ready, busy, done} !== 7'b1100100) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want %b", {sync, sclk, dout, load_ready, busy, done}, 7'b1100100);
    end
    vectors++;
    if ({b_sync, b_sclk, b_dout, b_load_ready, b_busy, b_done} !== 6'b110100) begin
      miscompares++;
      $display("FAIL reset_outputs_lsb got %b want %b", {b_sync, b_sclk, b_dout, b_load_ready, b_busy, b_done}, 6'b110100);
    end
    load_valid = 1'b0;
    reset = 1'b0;
    tick();
    vectors++;
    if ({sync, busy, load_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL reset_priority_no_capture got %b want %b", {sync, busy, load_ready}, 3'b101);
    end
    repeat (2) tick();
    flush_obs();
  endtask

  task automatic test_single_frame();
    logic [15:0] w0, w1, g0, g1;
    int done_at, pulses, d0, lr;
    w0 = 16'hA5C3; w1 = 16'h0F0F;
    done_at = 0; pulses = 0; d0 = done_cnt;
    flush_obs();
    exp0.push_back(w0); exp1.push_back(w1);
    load_data = {w1, w0}; load_valid = 1'b1;
    @(posedge clk); #1; load_valid = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (n == 1) begin
        vectors++;
        if ({sync, sclk, busy, load_ready, dout} !== {1'b0, 1'b1, 1'b1, 1'b0, w1[15], w0[15]}) begin
          miscompares++;
          $display("FAIL single_first_cycle got %b want %b", {sync, sclk, busy, load_ready, dout},
                   {1'b0, 1'b1, 1'b1, 1'b0, w1[15], w0[15]});
        end
      end
      if (n == 3 || n == 5) begin
        vectors++;
        if (sclk !== (n == 5)) begin
          miscompares++;
          $display("FAIL single_sclk_phase cycle %0d got %b want %b", n, sclk, (n == 5));
        end
      end
      if (done === 1'b1) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
    end
    vectors++;
    if (done_at != 65 || pulses != 1) begin
      miscompares++;
      $display("FAIL single_done_timing got cycle %0d pulses %0d want cycle 65 pulses 1", done_at, pulses);
    end
    if (exp0.size() > 0) w0 = exp0.pop_front();
    if (exp1.size() > 0) w1 = exp1.pop_front();
    if (obs0.size() > 0) g0 = obs0.pop_front(); else g0 = 'x;
    if (obs1.size() > 0) g1 = obs1.pop_front(); else g1 = 'x;
    if (low_q.size() > 0) lr = low_q.pop_front(); else lr = -1;
    vectors++;
    if (g0 !== w0) begin
      miscompares++;
      $display("FAIL single_ch0_bits got %b want %b", g0, w0);
    end
    vectors++;
    if (g1 !== w1) begin
      miscompares++;
      $display("FAIL single_ch1_bits got %b want %b", g1, w1);
    end
    vectors++;
    if (lr != 64) begin
      miscompares++;
      $display("FAIL single_sync_low got %0d want 64", lr);
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL single_done_count got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3];
    logic [15:0] g0, g1, e0, e1;
    int d0, guard, lr;
    words[0] = {16'hABCD, 16'h1234};
    words[1] = {16'hC3C3, 16'h5A5A};
    words[2] = {16'h7FFF, 16'hFFFE};
    flush_obs();
    d0 = done_cnt;
    tick();
    load_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      load_data = words[f];
      exp0.push_back(words[f][15:0]);
      exp1.push_back(words[f][31:16]);
      guard = 0;
      while (load_ready !== 1'b1 && guard < 300) begin
        tick();
        guard++;
      end
      if (guard >= 300) begin
        vectors++; miscompares++;
        $display("FAIL stream_ready_timeout frame %0d ready %b want 1", f, load_ready);
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    repeat (80) tick();
    vectors++;
    if (done_cnt - d0 != 3) begin
      miscompares++;
      $display("FAIL stream_done_count got %0d want 3", done_cnt - d0);
    end
    for (int f = 0; f < 3; f++) begin
      e0 = (exp0.size() > 0) ? exp0.pop_front() : 16'h0;
      e1 = (exp1.size() > 0) ? exp1.pop_front() : 16'h0;
      if (obs0.size() > 0) g0 = obs0.pop_front(); else g0 = 'x;
      if (obs1.size() > 0) g1 = obs1.pop_front(); else g1 = 'x;
      if (low_q.size() > 0) lr = low_q.pop_front(); else lr = -1;
      vectors++;
      if ({g1, g0} !== {e1, e0}) begin
        miscompares++;
        $display("FAIL stream_frame%0d_data got %h want %h", f, {g1, g0}, {e1, e0});
      end
      vectors++;
      if (lr != 64) begin
        miscompares++;
        $display("FAIL stream_frame%0d_sync_low got %0d want 64", f, lr);
      end
    end
    for (int f = 1; f < 3; f++) begin
      vectors++;
      if (hi_q.size() <= f || hi_q[f] != 2) begin
        miscompares++;
        $display("FAIL stream_gap%0d got %0d want 2", f, (hi_q.size() > f) ? hi_q[f] : -1);
      end
    end
  endtask

  task automatic test_busy_drop();
    logic [15:0] e0, e1, g0, g1;
    int d0, ready_bad, nfr;
    flush_obs();
    d0 = done_cnt; ready_bad = 0;
    tick();
    e0 = 16'h1234; e1 = 16'h5678;
    exp0.push_back(e0); exp1.push_back(e1);
    load_data = {e1, e0}; load_valid = 1'b1;
    @(posedge clk); #1; load_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n >= 10 && n <= 65 && load_ready !== 1'b0) ready_bad++;
      if (n == 10) begin
        load_valid = 1'b1;
        load_data = 32'hFFFF_FFFF;
      end
      if (done === 1'b1 || n == 70) load_valid = 1'b0;
    end
    nfr = obs0.size();
    vectors++;
    if (ready_bad != 0) begin
      miscompares++;
      $display("FAIL busy_ready_low got %0d high cycles want 0", ready_bad);
    end
    vectors++;
    if (nfr != 1 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL busy_extra_frame got frames %0d dones %0d want 1 1", nfr, done_cnt - d0);
    end
    e0 = exp0.pop_front(); e1 = exp1.pop_front();
    if (obs0.size() > 0) g0 = obs0.pop_front(); else g0 = 'x;
    if (obs1.size() > 0) g1 = obs1.pop_front(); else g1 = 'x;
    vectors++;
    if ({g1, g0} !== {e1, e0}) begin
      miscompares++;
      $display("FAIL busy_data_unchanged got %h want %h", {g1, g0}, {e1, e0});
    end
    vectors++;
    if ({sync, busy, load_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL busy_back_to_idle got %b want %b", {sync, busy, load_ready}, 3'b101);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] e0, e1, g0, g1;
    int d0, lr;
    flush_obs();
    d0 = done_cnt;
    tick();
    load_data = {16'h2222, 16'h1111}; load_valid = 1'b1;
    @(posedge clk); #1; load_valid = 1'b0;
    repeat (20) tick();
    reset = 1'b1; load_valid = 1'b1;
    tick();
    reset = 1'b0; load_valid = 1'b0;
    vectors++;
    if ({sync, sclk, dout, load_ready, busy, done} !== 7'b1100100) begin
      miscompares++;
      $display("FAIL midreset_idle got %b want %b", {sync, sclk, dout, load_ready, busy, done}, 7'b1100100);
    end
    repeat (70) tick();
    vectors++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_done got dones %0d busy %b want 0 0", done_cnt - d0, busy);
    end
    flush_obs();
    e0 = 16'h8001; e1 = 16'h8001;
    exp0.push_back(e0); exp1.push_back(e1);
    load_data = {e1, e0}; load_valid = 1'b1;
    @(posedge clk); #1; load_valid = 1'b0;
    repeat (80) tick();
    e0 = exp0.pop_front(); e1 = exp1.pop_front();
    if (obs0.size() > 0) g0 = obs0.pop_front(); else g0 = 'x;
    if (obs1.size() > 0) g1 = obs1.pop_front(); else g1 = 'x;
    if (low_q.size() > 0) lr = low_q.pop_front(); else lr = -1;
    vectors++;
    if ({g1, g0} !== {e1, e0}) begin
      miscompares++;
      $display("FAIL midreset_next_frame got %h want %h", {g1, g0}, {e1, e0});
    end
    vectors++;
    if (lr != 64 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL midreset_next_timing got low %0d dones %0d want 64 1", lr, done_cnt - d0);
    end
  endtask

  task automatic test_lsb_first();
    logic [15:0] e, g;
    logic        f;
    int          lr;
    b_exp.delete(); b_obs.delete(); b_first_q.delete(); b_low_q.delete();
    tick();
    // LSB first: 0x0001 goes out as a single 1 followed by fifteen 0s.
    b_exp.push_back(16'h8000);
    b_load_data = 16'h0001; b_load_valid = 1'b1;
    @(posedge clk); #1; b_load_valid = 1'b0;
    repeat (50) tick();
    e = b_exp.pop_front();
    if (b_obs.size() > 0) g = b_obs.pop_front(); else g = 'x;
    if (b_first_q.size() > 0) f = b_first_q.pop_front(); else f = 1'bx;
    if (b_low_q.size() > 0) lr = b_low_q.pop_front(); else lr = -1;
    vectors++;
    if (f !== 1'b1) begin
      miscompares++;
      $display("FAIL lsb_first_bit got %b want 1", f);
    end
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL lsb_sequence got %b want %b", g, e);
    end
    vectors++;
    if (lr != 32) begin
      miscompares++;
      $display("FAIL lsb_sync_low got %0d want 32", lr);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    b_load_valid = 1'b0;
    b_load_data = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_drop();
    test_mid_reset();
    test_lsb_first();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per DAC word; legal range >= 2.
REQ-002 SHALL have parameter NUM_CH, default 2, number of parallel DAC data lines sharing one sync and sclk; legal range >= 1.
REQ-003 SHALL have parameter CLK_DIV, default 2, clk cycles per sclk half-period; legal range >= 1.
REQ-004 SHALL have parameter GAP_CYC, default 1, minimum sync-high clk cycles after each frame; legal range >= 1.
REQ-005 SHALL have parameter MSB_FIRST, default 1; 1 shifts the MSB first, 0 shifts the LSB first.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-007 SHALL have port reset  input  1  reset, synchronous to clk and active-high.
REQ-008 SHALL have port load_data  input  NUM_CH*DATA_W  channel k word at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port load_valid  input  1  load_data is valid this cycle.
REQ-010 SHALL have port load_ready  output  1  block accepts a frame this cycle.
REQ-011 SHALL have port sclk  output  1  serial clock to the DAC(s).
REQ-012 SHALL have port dout  output  NUM_CH  serial data; bit k drives channel k.
REQ-013 SHALL have port sync  output  1  frame sync, active-low during a frame.
REQ-014 SHALL have port busy  output  1  high from the cycle after accept until return to IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a frame completes normally.

Function
REQ-016 SHALL implement states IDLE, SHIFT and GAP as a registered FSM; all outputs SHALL be registered.
REQ-017 SHALL, in IDLE, drive load_ready=1, sync=1, sclk=1, dout=0, busy=0.
REQ-018 SHALL accept a frame only on a clk edge where load_valid=1 and load_ready=1, capturing all NUM_CH words into per-channel shift registers.
REQ-019 SHALL, in the cycle after accept, be in SHIFT with sync=0, sclk=1, busy=1, load_ready=0, and dout[k] = first bit of word k (selected by MSB_FIRST).
REQ-020 SHALL hold each bit for 2*CLK_DIV clk cycles: sclk=1 for the first CLK_DIV cycles and sclk=0 for the last CLK_DIV cycles, so the DAC samples on the sclk falling edge at mid-bit.
REQ-021 SHALL advance all shift registers by one bit at the end of each bit period, which is also the sclk rising edge.
REQ-022 SHALL keep sync=0 for exactly DATA_W*2*CLK_DIV clk cycles per frame.
REQ-023 SHALL, after the last bit period, enter GAP with sync=1, sclk=1, dout=0 for GAP_CYC cycles, then enter IDLE.
REQ-024 SHALL pulse done=1 for exactly one cycle, in the first GAP cycle.
REQ-025 SHALL ignore load_valid and load_data while in SHIFT or GAP; no capture and no state change.
REQ-026 SHALL, with load_valid held high, run frames back-to-back with sync high for exactly GAP_CYC+1 cycles between frames (GAP plus one IDLE cycle).
REQ-027 SHALL size the divider counter and bit counter as $clog2 of their ranges, so that no wrap occurs before the terminal count.
REQ-028 SHALL shift in 0 at the vacated end of each shift register.

Reset
REQ-029 SHALL, on any clk edge with reset=1 and in any state, enter IDLE with load_ready=1, sync=1, sclk=1, dout=0, busy=0, done=0, and counters and shift registers cleared.
REQ-030 SHALL abort an in-progress frame on reset without a done pulse; reset SHALL take priority over a simultaneous load_valid.

Verification
REQ-031 Reset check: assert reset 3 cycles -> sync=1, sclk=1, dout=0, load_ready=1, busy=0, done=0.
REQ-032 Single frame, defaults: ch0=0xA5C3, ch1=0x0F0F, one-cycle load_valid -> sync low 64 cycles; dout[0] at sclk falls = 1010010111000011; dout[1] at sclk falls = 0000111100001111; done at cycle 65 after accept.
REQ-033 Streaming: load_valid held high for 3 frames -> 3 done pulses; sync high exactly 2 cycles between frames; each frame carries its own data.
REQ-034 Busy drop: load_valid=1 with 0xFFFF at cycle 10 of a frame -> frame data unchanged; no extra frame; load_ready stays 0 until IDLE.
REQ-035 Mid-frame reset: reset at cycle 20 of a frame -> idle outputs next cycle; no done pulse; next accepted frame 0x8001 serialises correctly.
REQ-036 Mode: MSB_FIRST=0, CLK_DIV=1, word 0x0001 -> first sampled bit 1, then 15 zeros; sync low exactly 32 cycles.
